// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: key indexing,
// debounce state encoding and the single-key snapshot evaluation.
package keypad_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;
  localparam int KEY_IDX_W = $clog2(NUM_KEYS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // Key index is 4*column + row, so idx[1:0] is the row and idx[3:2] the column.
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef struct packed {
    logic     valid;
    key_idx_t idx;
  } cand_t;

  localparam cand_t CAND_NONE = '{valid: 1'b0, idx: {KEY_IDX_W{1'b0}}};

  // Exactly one closed switch yields that key; zero or several (ghosting) yield none.
  function automatic cand_t eval_snapshot(input logic [NUM_KEYS-1:0] snap);
    cand_t      c;
    logic [4:0] count;
    c     = CAND_NONE;
    count = 5'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (snap[k]) begin
        count = count + 5'd1;
        c.idx = key_idx_t'(k);
      end else begin
        count = count;
      end
    end
    if (count == 5'd1) begin
      c.valid = 1'b1;
    end else begin
      c = CAND_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row returns.
module keypad_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability-settling flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column strobing, row sampling, ghost rejection and
// debounced commit of a single key as one-hot row/column codes with pulses.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_drv,
  output logic [NUM_ROWS-1:0] row_code,
  output logic [NUM_COLS-1:0] col_code,
  output logic                key_valid,
  output logic                key_press,
  output logic                key_release
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [1:0]       LAST_COL = 2'd3;

  logic [NUM_ROWS-1:0] row_sync_s;
  logic                slot_end_s;
  logic                scan_end_s;
  logic                settled_s;
  logic                commit_s;
  logic                clear_s;
  cand_t               cand_s;
  cand_t               held_s;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          col_q, col_d;
  logic [NUM_COLS-1:0] col_drv_q, col_drv_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  cand_t               prev_q, prev_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  deb_state_e          state_q, state_d;
  key_idx_t            key_q, key_d;
  logic [NUM_ROWS-1:0] row_code_q, row_code_d;
  logic [NUM_COLS-1:0] col_code_q, col_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_press_q, key_press_d;
  logic                key_release_q, key_release_d;

  keypad_sync2 #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_in),
    .q_o   (row_sync_s)
  );

  // Slot counter, column rotation and per-column row capture.
  always_comb begin
    slot_end_s = (cnt_q == CNT_LAST);
    scan_end_s = slot_end_s && (col_q == LAST_COL);
    cnt_d      = cnt_q;
    col_d      = col_q;
    col_drv_d  = col_drv_q;
    snap_d     = snap_q;
    if (slot_end_s) begin
      cnt_d     = {CNT_W{1'b0}};
      col_d     = col_q + 2'd1;
      col_drv_d = {col_drv_q[NUM_COLS-2:0], col_drv_q[NUM_COLS-1]};
      snap_d[{col_q, 2'b00} +: NUM_ROWS] = row_sync_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The evaluation sees this scan's column-3 capture, hence snap_d rather than snap_q.
  always_comb begin
    cand_s = eval_snapshot(snap_d);
    held_s = '{valid: 1'b1, idx: key_q};
  end

  // Stability tracking and debounce FSM; commits land in the registers at scan end.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    stable_d      = stable_q;
    key_d         = key_q;
    row_code_d    = row_code_q;
    col_code_d    = col_code_q;
    key_valid_d   = key_valid_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    settled_s     = 1'b0;
    commit_s      = 1'b0;
    clear_s       = 1'b0;
    if (scan_end_s) begin
      prev_d = cand_s;
      if (cand_s != prev_q) begin
        stable_d = STB_W'(1);
      end else if (stable_q != STB_MAX) begin
        stable_d = stable_q + STB_W'(1);
      end else begin
        stable_d = stable_q;
      end
      settled_s = (stable_d == STB_MAX);
      case (state_q)
        IDLE: begin
          if (cand_s.valid) state_d = PRESS_WAIT;
          else              state_d = IDLE;
        end
        PRESS_WAIT: begin
          if (!cand_s.valid) begin
            state_d = IDLE;
          end else if (settled_s) begin
            commit_s = 1'b1;
            state_d  = HELD;
          end else begin
            state_d = PRESS_WAIT;
          end
        end
        HELD: begin
          if (cand_s != held_s) state_d = RELEASE_WAIT;
          else                  state_d = HELD;
        end
        RELEASE_WAIT: begin
          if (cand_s == held_s) begin
            state_d = HELD;
          end else if (settled_s && cand_s.valid) begin
            commit_s = 1'b1;
            state_d  = HELD;
          end else if (settled_s) begin
            clear_s = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RELEASE_WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
      if (commit_s) begin
        key_d       = cand_s.idx;
        row_code_d  = 4'b0001 << cand_s.idx[1:0];
        col_code_d  = 4'b0001 << cand_s.idx[3:2];
        key_valid_d = 1'b1;
        key_press_d = 1'b1;
      end else if (clear_s) begin
        key_d         = {KEY_IDX_W{1'b0}};
        row_code_d    = 4'b0000;
        col_code_d    = 4'b0000;
        key_valid_d   = 1'b0;
        key_release_d = 1'b1;
      end else begin
        key_d = key_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= {CNT_W{1'b0}};
      col_q         <= 2'd0;
      col_drv_q     <= 4'b0001;
      snap_q        <= {NUM_KEYS{1'b0}};
      prev_q        <= CAND_NONE;
      stable_q      <= {STB_W{1'b0}};
      state_q       <= IDLE;
      key_q         <= {KEY_IDX_W{1'b0}};
      row_code_q    <= 4'b0000;
      col_code_q    <= 4'b0000;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      col_drv_q     <= col_drv_d;
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      stable_q      <= stable_d;
      state_q       <= state_d;
      key_q         <= key_d;
      row_code_q    <= row_code_d;
      col_code_q    <= col_code_d;
      key_valid_q   <= key_valid_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign col_drv     = col_drv_q;
  assign row_code    = row_code_q;
  assign col_code    = col_code_q;
  assign key_valid   = key_valid_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule
